// File: rtl/prog_pla_pkg.sv
// Shared constants and width helpers for the programmable registered PLA.
package prog_pla_pkg;

  // Plane selector values on prog_sel.
  localparam logic SEL_AND = 1'b0;
  localparam logic SEL_OR  = 1'b1;

  // Literal count: state bits sit above the primary inputs.
  function automatic int nl_width(input int n_in, input int n_st);
    return n_in + n_st;
  endfunction

  // Programming word: wide enough for either an AND row or an OR row.
  function automatic int pw_width(input int n_in, input int n_st, input int n_out);
    int and_w;
    int or_w;
    and_w = 2 * (n_in + n_st);
    or_w  = n_out + n_st;
    return (and_w > or_w) ? and_w : or_w;
  endfunction

  // Product-term index width, never narrower than one bit.
  function automatic int addr_width(input int n_pt);
    return (n_pt > 2) ? $clog2(n_pt) : 1;
  endfunction

endpackage

// File: rtl/pla_term.sv
// One AND-plane product term: two mask bits per literal select the true
// and/or complemented literal; both set forces the term low.
module pla_term
  import prog_pla_pkg::*;
#(
  parameter int NL = 3
) (
  input  logic [2*NL-1:0] mask,
  input  logic [NL-1:0]   lits,
  output logic            term
);

  logic [NL-1:0] miss;

  // A literal misses when its included polarity is not the one present.
  // NOTE: always_comb assigns a default first so no path leaves miss unassigned (no latch).
  always_comb begin
    miss = '0;
    for (int i = 0; i < NL; i++) begin
      miss[i] = (mask[2*i] & ~lits[i]) | (mask[2*i+1] & lits[i]);
    end
    term = ~|miss;
  end

endmodule

// File: rtl/prog_pla.sv
// Run-time programmable registered PLA with optional state feedback.
// AND/OR rows are loaded one per accepted write on a valid/ready port.
module prog_pla
  import prog_pla_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int N_ST  = 0,
  parameter  int N_PT  = 8,
  parameter  int N_OUT = 4,
  localparam int NL    = nl_width(N_IN, N_ST),
  localparam int PW    = pw_width(N_IN, N_ST, N_OUT),
  localparam int AW    = addr_width(N_PT),
  localparam int STW   = (N_ST > 0) ? N_ST : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_IN-1:0]  x,
  input  logic             prog_valid,
  output logic             prog_ready,
  input  logic             prog_sel,
  input  logic [AW-1:0]    prog_addr,
  input  logic [PW-1:0]    prog_data,
  output logic             prog_err,
  output logic [N_OUT-1:0] y,
  output logic [STW-1:0]   st
);

  localparam int ANDW = 2 * NL;
  localparam int ORW  = N_OUT + N_ST;
  localparam logic [AW:0] PT_LIM = (AW+1)'(N_PT);

  logic [ANDW-1:0]  and_plane [N_PT];
  logic [ORW-1:0]   or_plane  [N_PT];
  logic [N_PT-1:0]  term;
  logic [NL-1:0]    lits;
  logic [N_OUT-1:0] y_n;
  logic [STW-1:0]   st_n;
  logic             busy;
  logic             accept;
  logic             addr_ok;

  assign prog_ready = ~busy;
  assign accept     = prog_valid & ~busy;
  assign addr_ok    = ({1'b0, prog_addr} < PT_LIM);

  // Literal vector: registered state above the primary inputs.
  if (N_ST > 0) begin : g_fb
    assign lits = {st, x};
  end else begin : g_nofb
    assign lits = x;
  end

  // AND plane: one term evaluator per row.
  for (genvar r = 0; r < N_PT; r++) begin : g_term
    pla_term #(.NL(NL)) u_term (
      .mask (and_plane[r]),
      .lits (lits),
      .term (term[r])
    );
  end

  // OR plane, output columns: y_n[j] collects every term routed to it.
  always_comb begin
    y_n = '0;
    for (int r = 0; r < N_PT; r++) begin
      y_n = y_n | ({N_OUT{term[r]}} & or_plane[r][N_OUT-1:0]);
    end
  end

  if (N_ST > 0) begin : g_st_n
    // OR plane, state columns feeding the next FSM state.
    always_comb begin
      st_n = '0;
      for (int r = 0; r < N_PT; r++) begin
        st_n = st_n | ({N_ST{term[r]}} & or_plane[r][ORW-1:N_OUT]);
      end
    end
  end else begin : g_st_tie
    assign st_n = '0;
  end

  // Plane storage: reset clears every term, accepted in-range writes load one row.
  // NOTE: the planes are reset because all-terms-off is the defined power-up function.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N_PT; r++) begin
        and_plane[r] <= '1;
        or_plane[r]  <= '0;
      end
    end else if (accept && addr_ok) begin
      if (prog_sel == SEL_AND) begin
        and_plane[prog_addr] <= prog_data[ANDW-1:0];
      end else begin
        or_plane[prog_addr] <= prog_data[ORW-1:0];
      end
    end
  end

  // Programming control: one busy cycle after each accept, error pulse for bad index.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      busy     <= accept;
      prog_err <= accept & ~addr_ok;
    end
  end

  // Evaluation registers: update on enabled edges, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y  <= '0;
      st <= '0;
    end else if (en) begin
      y  <= y_n;
      st <= st_n;
    end
  end

endmodule

// File: tb/tb_prog_pla.sv
// Directed bench for prog_pla: plain SOP instance (defaults) and an FSM
// instance (N_ST=2, N_PT=6) for the counter, bad-address and reset scenarios.
module tb_prog_pla;

  logic       clk = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Default instance signals.
  logic       rst_n, en, prog_valid, prog_sel, prog_ready, prog_err;
  logic [2:0] x, prog_addr;
  logic [5:0] prog_data;
  logic [3:0] y;
  logic [0:0] st;

  // FSM instance signals.
  logic       f_rst_n, f_en, f_valid, f_sel, f_ready, f_err;
  logic [2:0] f_x, f_addr;
  logic [9:0] f_data;
  logic [3:0] f_y;
  logic [1:0] f_st;

  localparam logic       W_SEL  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [2:0] W_ADDR [4] = '{3'd2, 3'd5, 3'd5, 3'd2};
  localparam logic [5:0] W_DATA [4] = '{6'h04, 6'h00, 6'h3F, 6'h00};

  always #5 clk = ~clk;

  prog_pla u_pla (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err),
    .y(y), .st(st)
  );

  prog_pla #(.N_IN(3), .N_ST(2), .N_PT(6), .N_OUT(4)) u_fsm (
    .clk(clk), .rst_n(f_rst_n), .en(f_en), .x(f_x),
    .prog_valid(f_valid), .prog_ready(f_ready), .prog_sel(f_sel),
    .prog_addr(f_addr), .prog_data(f_data), .prog_err(f_err),
    .y(f_y), .st(f_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived truth table: y0 = x0&x1, y1 = y3 = ~x2.
  function automatic logic [3:0] sop_exp(input logic [2:0] v);
    return {~v[2], 1'b0, ~v[2], v[0] & v[1]};
  endfunction

  task automatic pwrite(input logic sel, input logic [2:0] addr, input logic [5:0] data);
    int n;
    n = 0;
    while (prog_ready !== 1'b1 && n < 8) begin tick(); n++; end
    if (prog_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL pwrite_ready got=%b want=1", prog_ready);
    end
    prog_valid = 1'b1; prog_sel = sel; prog_addr = addr; prog_data = data;
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic fwrite(input logic sel, input logic [2:0] addr, input logic [9:0] data);
    int n;
    n = 0;
    while (f_ready !== 1'b1 && n < 8) begin tick(); n++; end
    if (f_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL fwrite_ready got=%b want=1", f_ready);
    end
    f_valid = 1'b1; f_sel = sel; f_addr = addr; f_data = data;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; x = 3'b111;
    prog_valid = 1'b1; prog_sel = 1'b1; prog_addr = 3'd0; prog_data = 6'h3F;
    f_rst_n = 1'b0; f_en = 1'b1; f_x = 3'b000;
    f_valid = 1'b1; f_sel = 1'b1; f_addr = 3'd0; f_data = 10'h3FF;
    tick(); tick();
    total++; if (y !== 4'h0) begin bad++; $display("FAIL reset_y got=%h want=0", y); end
    total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", prog_ready); end
    total++; if (prog_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", prog_err); end
    total++; if (f_st !== 2'd0) begin bad++; $display("FAIL reset_fst got=%0d want=0", f_st); end
    total++; if (f_ready !== 1'b1) begin bad++; $display("FAIL reset_fready got=%b want=1", f_ready); end
    prog_valid = 1'b0; f_valid = 1'b0;
    rst_n = 1'b1; f_rst_n = 1'b1;
    tick();
    total++; if (y !== 4'h0) begin bad++; $display("FAIL post_reset_y got=%h want=0", y); end
    total++; if (f_y !== 4'h0 || f_st !== 2'd0) begin
      bad++; $display("FAIL post_reset_fsm got y=%h st=%0d want y=0 st=0", f_y, f_st);
    end
    total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", prog_ready); end
    en = 1'b0; f_en = 1'b0;
  endtask

  task automatic test_sop_sweep();
    logic [3:0] prev;
    pwrite(1'b0, 3'd0, 6'h05);  // term0 = x0 & x1
    pwrite(1'b1, 3'd0, 6'h01);  // -> y0
    pwrite(1'b0, 3'd1, 6'h20);  // term1 = ~x2
    pwrite(1'b1, 3'd1, 6'h0A);  // -> y1, y3
    x = 3'b111; en = 1'b1;
    tick();
    prev = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      #1;
      total++; if (y !== prev) begin bad++; $display("FAIL sop_no_comb x=%b got=%b want=%b", x, y, prev); end
      tick();
      total++; if (y !== sop_exp(3'(i))) begin bad++; $display("FAIL sop_eval x=%b got=%b want=%b", x, y, sop_exp(3'(i))); end
      prev = sop_exp(3'(i));
      repeat (29) tick();
    end
  endtask

  // Valid held high; busy cycles present a poison write that must be ignored.
  task automatic test_back_to_back();
    logic exp_rdy;
    for (int e = 1; e <= 7; e++) begin
      prog_valid = 1'b1;
      exp_rdy = (e % 2 == 1);
      if (exp_rdy) begin
        prog_sel = W_SEL[(e-1)/2]; prog_addr = W_ADDR[(e-1)/2]; prog_data = W_DATA[(e-1)/2];
      end else begin
        prog_sel = 1'b0; prog_addr = 3'd2; prog_data = 6'h00;
      end
      total++; if (prog_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready edge=%0d got=%b want=%b", e, prog_ready, exp_rdy); end
      tick();
      total++; if (y !== 4'b0001) begin bad++; $display("FAIL b2b_old_y edge=%0d got=%b want=0001", e, y); end
    end
    prog_valid = 1'b0;
    tick();
    total++; if (y !== 4'b0101) begin bad++; $display("FAIL b2b_new_y got=%b want=0101", y); end
    total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_end got=%b want=1", prog_ready); end
  endtask

  // 2-bit up-counter; y0 registered alongside st==3.
  task automatic test_fsm_counter();
    logic [1:0] exp_st;
    f_en = 1'b0;
    fwrite(1'b0, 3'd0, 10'h080); fwrite(1'b1, 3'd0, 10'h010);  // ~st0 -> st0
    fwrite(1'b0, 3'd1, 10'h180); fwrite(1'b1, 3'd1, 10'h021);  // st1&~st0 -> st1, y0
    fwrite(1'b0, 3'd2, 10'h240); fwrite(1'b1, 3'd2, 10'h020);  // ~st1&st0 -> st1
    total++; if (f_st !== 2'd0) begin bad++; $display("FAIL fsm_start got=%0d want=0", f_st); end
    f_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_st = 2'(k % 4);
      total++; if (f_st !== exp_st) begin bad++; $display("FAIL fsm_st step=%0d got=%0d want=%0d", k, f_st, exp_st); end
      total++; if (f_y !== {3'b000, exp_st == 2'd3}) begin
        bad++; $display("FAIL fsm_y step=%0d got=%b want=%b", k, f_y, {3'b000, exp_st == 2'd3});
      end
    end
    f_en = 1'b0;
    repeat (3) begin
      tick();
      total++; if (f_st !== 2'd2 || f_y !== 4'h0) begin
        bad++; $display("FAIL fsm_hold got st=%0d y=%b want st=2 y=0000", f_st, f_y);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [2:0] addrs [3];
    logic       exp_err;
    logic [1:0] exp_st;
    addrs = '{3'd6, 3'd7, 3'd5};
    for (int i = 0; i < 3; i++) begin
      exp_err = (addrs[i] >= 3'd6);
      fwrite(1'b0, addrs[i], (addrs[i] == 3'd5) ? 10'h3FF : 10'h000);
      total++; if (f_err !== exp_err) begin bad++; $display("FAIL bad_addr_err addr=%0d got=%b want=%b", addrs[i], f_err, exp_err); end
      tick();
      total++; if (f_err !== 1'b0) begin bad++; $display("FAIL bad_addr_pulse addr=%0d got=%b want=0", addrs[i], f_err); end
    end
    total++; if (f_st !== 2'd2 || f_y !== 4'h0) begin
      bad++; $display("FAIL bad_addr_hold got st=%0d y=%b want st=2 y=0000", f_st, f_y);
    end
    f_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_st = 2'((2 + k) % 4);
      total++; if (f_st !== exp_st || f_y[0] !== (exp_st == 2'd3)) begin
        bad++; $display("FAIL bad_addr_count step=%0d got st=%0d y0=%b want st=%0d y0=%b",
                        k, f_st, f_y[0], exp_st, exp_st == 2'd3);
      end
    end
  endtask

  task automatic test_reset_mid();
    f_en = 1'b0;
    f_valid = 1'b1; f_sel = 1'b1; f_addr = 3'd3; f_data = 10'h3FF;
    tick();
    f_valid = 1'b0;
    total++; if (f_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", f_ready); end
    f_rst_n = 1'b0;
    tick();
    total++; if (f_st !== 2'd0 || f_y !== 4'h0) begin
      bad++; $display("FAIL mid_reset got st=%0d y=%b want st=0 y=0000", f_st, f_y);
    end
    total++; if (f_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", f_ready); end
    f_rst_n = 1'b1; f_en = 1'b1;
    repeat (4) begin
      tick();
      total++; if (f_st !== 2'd0 || f_y !== 4'h0) begin
        bad++; $display("FAIL mid_cleared got st=%0d y=%b want st=0 y=0000", f_st, f_y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sop_sweep();
    test_back_to_back();
    test_fsm_counter();
    test_bad_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
